// File: rtl/shift_seq_unit.sv
// shift_seq_unit: chained A/B shift register with single-step and counted multi-cycle shifts
module shift_seq_unit #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 5
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] D,
  input  logic             Ld_A,
  input  logic             Ld_B,
  input  logic             Shift_En,
  input  logic             Start,
  input  logic [CNT_W-1:0] Count,
  input  logic [1:0]       Mode,
  input  logic             A_In,
  input  logic             B_In,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic             A_out,
  output logic             B_out,
  output logic             Busy,
  output logic             Done
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  localparam int VW = 2 * WIDTH;
  state_t           state_q, state_d;
  logic [VW-1:0]    v_q, v_d, step_v;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       mode_q, mode_d, m;
  always_comb begin
    m = (state_q == SHIFT) ? mode_q : Mode;
    step_v = (m == 2'b10) ? {v_q[VW-2:0], B_In}
           : {(m == 2'b00) ? A_In : (m == 2'b01) ? v_q[VW-1] : v_q[0], v_q[VW-1:1]};
    state_d = state_q;
    v_d = v_q;
    cnt_d = cnt_q;
    mode_d = mode_q;
    case (state_q)
      IDLE:
        if (Ld_A || Ld_B) v_d = {Ld_A ? D : v_q[VW-1:WIDTH], Ld_B ? D : v_q[WIDTH-1:0]};
        else if (Start) begin
          cnt_d = Count;
          mode_d = Mode;
          state_d = (Count == '0) ? DONE : SHIFT;
        end else if (Shift_En) v_d = step_v;
      SHIFT: begin
        v_d = step_v;
        cnt_d = cnt_q - CNT_W'(1);
        state_d = (cnt_q == CNT_W'(1)) ? DONE : SHIFT;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      state_q <= IDLE;
      v_q <= '0;
      cnt_q <= '0;
      mode_q <= 2'b00;
    end else begin
      state_q <= state_d;
      v_q <= v_d;
      cnt_q <= cnt_d;
      mode_q <= mode_d;
    end
  assign A = v_q[VW-1:WIDTH];
  assign B = v_q[WIDTH-1:0];
  assign A_out = v_q[WIDTH];
  assign B_out = v_q[0];
  assign Busy = (state_q == SHIFT);
  assign Done = (state_q == DONE);
endmodule

// File: tb/tb_shift_seq_unit.sv
// tb_shift_seq_unit: randomized scoreboard bench for shift_seq_unit against an arithmetic model
module tb_shift_seq_unit;
  localparam int W = 8;
  localparam int CW = 5;
  logic Clk = 0, Reset = 1;
  logic [W-1:0] D = '0;
  logic Ld_A = 0, Ld_B = 0, Shift_En = 0, Start = 0, A_In = 0, B_In = 0;
  logic [CW-1:0] Count = '0;
  logic [1:0] Mode = '0;
  logic [W-1:0] A, B;
  logic A_out, B_out, Busy, Done;

  shift_seq_unit #(.WIDTH(W), .CNT_W(CW)) dut (
    .Clk(Clk), .Reset(Reset), .D(D), .Ld_A(Ld_A), .Ld_B(Ld_B), .Shift_En(Shift_En),
    .Start(Start), .Count(Count), .Mode(Mode), .A_In(A_In), .B_In(B_In),
    .A(A), .B(B), .A_out(A_out), .B_out(B_out), .Busy(Busy), .Done(Done));

  always #5 Clk = ~Clk;

  typedef struct {logic [W-1:0] a; logic [W-1:0] b; int n;} exp_t;
  exp_t exp_q[$];
  int total = 0, passed = 0, busy_run = 0, done_total = 0;
  logic [W-1:0] ma = '0, mb = '0;

  task automatic chk(string name, longint act, longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // One step on the 2W-bit value {A,B}, expressed as integer arithmetic
  function automatic logic [2*W-1:0] mstep(logic [2*W-1:0] v, logic [1:0] m, logic ai, logic bi);
    longint u = v;
    longint top = longint'(1) << (2*W-1);
    longint half = u / 2;
    case (m)
      2'd0: return (2*W)'(half + (ai ? top : 0));
      2'd1: return (2*W)'(half + ((u >= top) ? top : 0));
      2'd2: return (2*W)'((u * 2) % (top * 2) + longint'(bi));
      default: return (2*W)'(half + (u % 2) * top);
    endcase
  endfunction

  always @(negedge Clk) begin
    if (Reset) busy_run = 0;
    else begin
      if (Busy) busy_run++;
      if (Done) begin
        exp_t e;
        done_total++;
        chk("busy_with_done", Busy, 0);
        if (exp_q.size() == 0) chk("unexpected_done", Done, 0);
        else begin
          e = exp_q.pop_front();
          chk("cmd_A", A, e.a);
          chk("cmd_B", B, e.b);
          chk("busy_cycles", busy_run, e.n);
        end
        busy_run = 0;
      end
    end
  end

  task automatic clr();
    Ld_A = 0; Ld_B = 0; Start = 0; Shift_En = 0;
  endtask

  task automatic load(logic [W-1:0] a, logic [W-1:0] b);
    @(negedge Clk); Ld_A = 1; D = a;
    @(negedge Clk); Ld_A = 0; Ld_B = 1; D = b;
    @(negedge Clk); Ld_B = 0;
    ma = a; mb = b;
    chk("load_A", A, ma);
    chk("load_B", B, mb);
  endtask

  task automatic load_both(logic [W-1:0] d);
    @(negedge Clk); Ld_A = 1; Ld_B = 1; D = d;
    @(negedge Clk); clr();
    ma = d; mb = d;
    chk("load_both_A", A, ma);
    chk("load_both_B", B, mb);
  endtask

  task automatic step1(logic [1:0] m, logic ai, logic bi);
    @(negedge Clk); Mode = m; A_In = ai; B_In = bi; Shift_En = 1;
    @(negedge Clk); Shift_En = 0;
    {ma, mb} = mstep({ma, mb}, m, ai, bi);
    chk("step_A", A, ma);
    chk("step_B", B, mb);
  endtask

  task automatic cmd(int n, logic [1:0] m, logic ai, logic bi);
    exp_t e;
    logic [2*W-1:0] v;
    int k;
    bit seen;
    v = {ma, mb};
    for (int i = 0; i < n; i++) v = mstep(v, m, ai, bi);
    {ma, mb} = v;
    e.a = ma; e.b = mb; e.n = n;
    exp_q.push_back(e);
    @(negedge Clk); Start = 1; Count = CW'(n); Mode = m; A_In = ai; B_In = bi;
    k = 0; seen = 0;
    while (!seen && k < n + 8) begin
      @(negedge Clk); k++;
      clr();
      if (Done) seen = 1;
      else begin
        Ld_A = 1; Ld_B = 1'($urandom); Start = 1'($urandom); Shift_En = 1'($urandom);
        D = W'($urandom); Mode = 2'($urandom); Count = CW'($urandom);
      end
    end
    clr();
    chk("done_latency", k, n + 1);
  endtask

  initial begin
    int dtot;
    #22;
    chk("reset_A", A, 0);
    chk("reset_B", B, 0);
    chk("reset_Busy", Busy, 0);
    chk("reset_Done", Done, 0);
    #5 Reset = 0;
    load(8'h02, 8'h00);
    step1(2'b00, 1'b1, 1'b0);
    chk("single_A_out", A_out, 1);
    chk("single_B_out", B_out, 0);
    load(8'h80, 8'h01);
    cmd(4, 2'b01, 1'b0, 1'b0);
    load(8'h12, 8'h34);
    cmd(16, 2'b11, 1'b0, 1'b0);
    load(8'h00, 8'hFF);
    cmd(3, 2'b10, 1'b0, 1'b1);
    cmd(0, 2'b01, 1'b1, 1'b1);
    cmd(5, 2'b00, 1'b1, 1'b0);
    cmd(31, 2'b11, 1'b0, 1'b0);
    repeat (4) @(negedge Clk);
    chk("idle_hold_A", A, ma);
    chk("idle_hold_B", B, mb);
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0: load(W'($urandom), W'($urandom));
        1: load_both(W'($urandom));
        2: step1(2'($urandom), 1'($urandom), 1'($urandom));
        default: cmd(int'($urandom_range(0, 31)), 2'($urandom), 1'($urandom), 1'($urandom));
      endcase
    end
    load(8'h81, 8'h5A);
    @(negedge Clk); Start = 1; Count = 5'd3; Mode = 2'b00;
    @(negedge Clk); clr();
    @(posedge Clk); #2 Reset = 1;
    #1;
    chk("rst_mid_A", A, 0);
    chk("rst_mid_B", B, 0);
    chk("rst_mid_Busy", Busy, 0);
    chk("rst_mid_Done", Done, 0);
    dtot = done_total;
    @(posedge Clk); #2 Reset = 0;
    ma = '0; mb = '0;
    load_both(8'h3C);
    repeat (6) @(negedge Clk);
    chk("no_done_after_reset", done_total, dtot);
    cmd(2, 2'b10, 1'b0, 1'b1);
    repeat (2) @(negedge Clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
